// File: rtl/syscall_sequencer.sv
// SYSCALL controller: freezes the pipeline, decodes $v0, hands print requests to the
// output device over valid/ready, and halts the CPU on the exit code.
module syscall_sequencer #(
    parameter logic [31:0] HALT_CODE  = 32'd10,
    parameter logic [31:0] PRINT_INT  = 32'd1,
    parameter logic [31:0] PRINT_HEX  = 32'd34,
    parameter logic [31:0] PRINT_CHAR = 32'd11,
    parameter logic [7:0]  TIMEOUT    = 8'd255,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sys_valid,
    input  logic [31:0]        v0,
    input  logic [31:0]        a0,
    output logic               stall,
    output logic               sys_ack,
    output logic               halt,
    output logic [31:0]        hex,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [1:0]         out_kind,
    output logic               bad_call,
    output logic               err_tmo,
    output logic [COUNT_W-1:0] sys_count
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StSend   = 3'd2;
    localparam logic [2:0] StDone   = 3'd3;
    localparam logic [2:0] StHalted = 3'd4;

    localparam logic [1:0] KindInt  = 2'd0;
    localparam logic [1:0] KindHex  = 2'd1;
    localparam logic [1:0] KindChar = 2'd2;

    logic [2:0]         state_q, state_d;
    logic [31:0]        v0_q, v0_d;
    logic [31:0]        a0_q, a0_d;
    logic [7:0]         tmo_q, tmo_d;
    logic [31:0]        hex_q, hex_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [1:0]         out_kind_q, out_kind_d;
    logic               bad_q, bad_d;
    logic               err_q, err_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] count_inc;
    logic               is_print;

    always_comb begin
        state_d     = state_q;
        v0_d        = v0_q;
        a0_d        = a0_q;
        tmo_d       = tmo_q;
        hex_d       = hex_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_kind_d  = out_kind_q;
        bad_d       = bad_q;
        err_d       = err_q;
        count_d     = count_q;
        is_print    = (v0_q == PRINT_INT) || (v0_q == PRINT_HEX) || (v0_q == PRINT_CHAR);
        count_inc   = (count_q != '1) ? count_q + 1'b1 : count_q;

        unique case (state_q)
            StIdle: begin
                if (sys_valid) begin
                    v0_d    = v0;
                    a0_d    = a0;
                    state_d = StDecode;
                end
            end
            // Decode only the captured copy; live inputs may already be moving.
            StDecode: begin
                if (v0_q == HALT_CODE) begin
                    state_d = StHalted;
                    count_d = count_inc;
                end else if (is_print) begin
                    state_d     = StSend;
                    tmo_d       = 8'd0;
                    out_valid_d = 1'b1;
                    if (v0_q == PRINT_INT) begin
                        out_kind_d = KindInt;
                        out_data_d = a0_q;
                    end else if (v0_q == PRINT_HEX) begin
                        out_kind_d = KindHex;
                        out_data_d = a0_q;
                    end else begin
                        out_kind_d = KindChar;
                        out_data_d = {24'b0, a0_q[7:0]};
                    end
                end else begin
                    state_d = StDone;
                    bad_d   = 1'b1;
                end
            end
            StSend: begin
                if (out_ready) begin
                    state_d     = StDone;
                    out_valid_d = 1'b0;
                    if (out_kind_q != KindChar) begin
                        hex_d = a0_q;
                    end
                end else if (tmo_q == TIMEOUT - 8'd1) begin
                    state_d     = StDone;
                    out_valid_d = 1'b0;
                    err_d       = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StDone: begin
                count_d = count_inc;
                state_d = StIdle;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            v0_q        <= 32'd0;
            a0_q        <= 32'd0;
            tmo_q       <= 8'd0;
            hex_q       <= 32'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_kind_q  <= 2'd0;
            bad_q       <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            v0_q        <= v0_d;
            a0_q        <= a0_d;
            tmo_q       <= tmo_d;
            hex_q       <= hex_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_kind_q  <= out_kind_d;
            bad_q       <= bad_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        stall = (state_q == StIdle) ? sys_valid : (state_q != StDone);
    end

    assign sys_ack   = (state_q == StDone);
    assign halt      = (state_q == StHalted);
    assign hex       = hex_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_kind  = out_kind_q;
    assign bad_call  = bad_q;
    assign err_tmo   = err_q;
    assign sys_count = count_q;

endmodule

// File: tb/tb_syscall_sequencer.sv
// Bench for syscall_sequencer: call-level reference model drives per-cycle expectations,
// checked by one compare process on every falling edge.
module tb_syscall_sequencer;

    localparam int TMO  = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          sys_valid;
    logic [31:0]   v0, a0;
    logic          stall, sys_ack, halt, out_valid, out_ready, bad_call, err_tmo;
    logic [31:0]   hex, out_data;
    logic [1:0]    out_kind;
    logic [CW-1:0] sys_count;

    syscall_sequencer #(
        .TIMEOUT (8'(TMO)),
        .COUNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sys_valid (sys_valid),
        .v0        (v0),
        .a0        (a0),
        .stall     (stall),
        .sys_ack   (sys_ack),
        .halt      (halt),
        .hex       (hex),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_kind  (out_kind),
        .bad_call  (bad_call),
        .err_tmo   (err_tmo),
        .sys_count (sys_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model state
    logic [31:0] m_hex;
    int          m_count;
    logic        m_bad, m_tmo, m_halt;

    // Expected outputs for the current cycle
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_ack, exp_valid;
    logic        exp_halt, exp_bad, exp_tmo;
    logic [31:0] exp_hex, exp_data;
    logic [1:0]  exp_kind;
    int          exp_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("sys_ack", 32'(sys_ack), 32'(exp_ack));
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("halt", 32'(halt), 32'(exp_halt));
            check("hex", hex, exp_hex);
            check("bad_call", 32'(bad_call), 32'(exp_bad));
            check("err_tmo", 32'(err_tmo), 32'(exp_tmo));
            check("sys_count", 32'(sys_count), 32'(exp_count));
            if (exp_valid) begin
                check("out_data", out_data, exp_data);
                check("out_kind", 32'(out_kind), 32'(exp_kind));
            end
        end
    end

    function automatic int sat(input int c);
        return (c >= CMAX) ? c : c + 1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_base(input logic s, input logic ack, input logic vld);
        exp_stall = s;
        exp_ack   = ack;
        exp_valid = vld;
        exp_halt  = m_halt;
        exp_hex   = m_hex;
        exp_bad   = m_bad;
        exp_tmo   = m_tmo;
        exp_count = m_count;
    endtask

    task automatic model_clear();
        m_hex   = 32'd0;
        m_count = 0;
        m_bad   = 1'b0;
        m_tmo   = 1'b0;
        m_halt  = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sys_valid = 1'b0;
        out_ready = 1'b0;
        cyc();
        model_clear();
        chk_en = 1'b1;
        expect_base(1'b0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sys_valid = 1'b0;
            v0        = $urandom;
            a0        = $urandom;
            out_ready = 1'($urandom);
            expect_base(m_halt, 1'b0, 1'b0);
            cyc();
        end
    endtask

    // lat: SEND cycles with ready low before it rises (-1: never). rst_at: SEND cycle to reset in.
    task automatic do_call(input logic [31:0] cv0, input logic [31:0] ca0, input int lat,
                           input int rst_at);
        logic is_print;
        if (m_halt) begin
            for (int i = 0; i < 3; i++) begin
                sys_valid = 1'b1;
                v0        = cv0;
                a0        = ca0;
                out_ready = 1'b1;
                expect_base(1'b1, 1'b0, 1'b0);
                cyc();
            end
            return;
        end
        sys_valid = 1'b1;
        v0        = cv0;
        a0        = ca0;
        out_ready = 1'($urandom);
        expect_base(1'b1, 1'b0, 1'b0);
        cyc();
        v0 = $urandom;
        a0 = $urandom;
        expect_base(1'b1, 1'b0, 1'b0);
        cyc();
        is_print = (cv0 == 32'd1) || (cv0 == 32'd34) || (cv0 == 32'd11);
        if (cv0 == 32'd10) begin
            m_halt  = 1'b1;
            m_count = sat(m_count);
            expect_base(1'b1, 1'b0, 1'b0);
            cyc();
            return;
        end
        if (!is_print) begin
            m_bad = 1'b1;
        end else begin
            exp_kind = (cv0 == 32'd1) ? 2'd0 : (cv0 == 32'd34) ? 2'd1 : 2'd2;
            exp_data = (cv0 == 32'd11) ? {24'b0, ca0[7:0]} : ca0;
            for (int k = 0; k < TMO; k++) begin
                out_ready = (lat >= 0) && (k >= lat);
                if (k == rst_at) begin
                    out_ready = 1'b0;
                    rst       = 1'b1;
                    expect_base(1'b1, 1'b0, 1'b1);
                    cyc();
                    rst       = 1'b0;
                    sys_valid = 1'b0;
                    model_clear();
                    expect_base(1'b0, 1'b0, 1'b0);
                    cyc();
                    return;
                end
                expect_base(1'b1, 1'b0, 1'b1);
                cyc();
                if (out_ready) begin
                    if (cv0 != 32'd11) m_hex = ca0;
                    break;
                end
                if (k == TMO - 1) m_tmo = 1'b1;
            end
        end
        out_ready = 1'($urandom);
        expect_base(1'b0, 1'b1, 1'b0);
        cyc();
        m_count = sat(m_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv0;
        int          lat;
        rst       = 1'b1;
        sys_valid = 1'b0;
        v0        = 32'd0;
        a0        = 32'd0;
        out_ready = 1'b0;
        exp_data  = 32'd0;
        exp_kind  = 2'd0;
        model_clear();
        expect_base(1'b0, 1'b0, 1'b0);
        do_reset();
        check("rst_hex", hex, 32'd0);
        check("rst_count", 32'(sys_count), 32'd0);

        do_call(32'd1, 32'hDEADBEEF, 0, -1);
        check("t1_hex", hex, 32'hDEADBEEF);
        check("t1_count", 32'(sys_count), 32'd1);

        do_call(32'd11, 32'h12345641, 5, -1);
        check("t2_hex_kept", hex, 32'hDEADBEEF);
        check("t2_count", 32'(sys_count), 32'd2);

        do_call(32'd34, 32'hCAFE0001, -1, -1);
        check("t3_err_tmo", 32'(err_tmo), 32'd1);
        check("t3_hex_kept", hex, 32'hDEADBEEF);

        idle(2);
        do_call(32'd7, 32'h0, 0, -1);
        check("t4_bad", 32'(bad_call), 32'd1);
        check("t4_count", 32'(sys_count), 32'd4);

        // ready arrives exactly on the last allowed SEND cycle
        do_call(32'd1, 32'h00000055, TMO - 1, -1);
        check("t_edge_hex", hex, 32'h00000055);

        do_call(32'd10, 32'h0, 0, -1);
        check("t5_halt", 32'(halt), 32'd1);
        check("t5_count", 32'(sys_count), 32'd6);
        do_call(32'd1, 32'h11111111, 0, -1);
        do_reset();
        check("t5_rst_halt", 32'(halt), 32'd0);
        check("t5_rst_hex", hex, 32'd0);

        do_call(32'd34, 32'hA5A5A5A5, 2, -1);
        do_call(32'd34, 32'h0BADF00D, -1, 2);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_count", 32'(sys_count), 32'd0);
        do_call(32'd1, 32'h00000123, 0, -1);
        do_call(32'd34, 32'h00000456, 1, -1);
        check("t6_hex", hex, 32'h00000456);
        check("t6_count2", 32'(sys_count), 32'd2);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: rv0 = 32'd1;
                1: rv0 = 32'd34;
                2: rv0 = 32'd11;
                default: begin
                    rv0 = $urandom;
                    if (rv0 == 32'd1 || rv0 == 32'd34 || rv0 == 32'd11 || rv0 == 32'd10)
                        rv0 = 32'd7;
                end
            endcase
            lat = int'($urandom_range(0, TMO + 1)) - 1;
            do_call(rv0, $urandom, lat, -1);
            idle(int'($urandom_range(0, 2)));
        end
        check("sat_count", 32'(sys_count), 32'(CMAX));

        do_call(32'd10, 32'h0, 0, -1);
        do_call(32'd34, 32'h1, 0, -1);
        check("sat_halt_count", 32'(sys_count), 32'(CMAX));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
